// File: rtl/mux_scan_pkg.sv
// Shared widths, FSM state type and select endpoints for the mux scan controller.
package mux_scan_pkg;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

   function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
      return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
   endfunction

   function automatic logic [SEL_W-1:0] sel_end(input bit msb_first);
      return msb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
   endfunction
endpackage

// File: rtl/mux_sel_cnt.sv
// Select counter for the downstream 8:1 mux: loads the first select, steps toward the last.
module mux_sel_cnt
   import mux_scan_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   output logic [SEL_W-1:0] sel
);
   logic [SEL_W-1:0] sel_d, sel_q;

   always_comb begin
      sel_d = sel_q;
      if (load)
         sel_d = sel_first(MSB_FIRST);
      else if (en)
         sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) sel_q <= sel_first(MSB_FIRST);
      else     sel_q <= sel_d;
   end

   assign sel = sel_q;
endmodule

// File: rtl/mux_scan_ctrl.sv
// Byte-to-serial scan controller: holds the active byte on I_OUT and walks S_OUT
// across it, with a one-byte prefetch buffer so consecutive bytes stream without gaps.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] DIN,
   input  logic              DIN_VALID,
   output logic              DIN_READY,
   output logic [DATA_W-1:0] I_OUT,
   output logic [SEL_W-1:0]  S_OUT,
   output logic              BIT_VALID,
   input  logic              BIT_READY,
   output logic              LAST,
   output logic [7:0]        BYTE_CNT
);
   state_e            state_d, state_q;
   logic [DATA_W-1:0] i_out_d, i_out_q;
   logic [DATA_W-1:0] buf_d, buf_q;
   logic              buf_full_d, buf_full_q;
   logic [7:0]        byte_cnt_d, byte_cnt_q;
   logic              sel_load, sel_en;
   logic              accept, xfer;

   mux_sel_cnt #(.MSB_FIRST(MSB_FIRST)) u_sel_cnt (
      .clk  (CLK),
      .rst  (RST),
      .load (sel_load),
      .en   (sel_en),
      .sel  (S_OUT)
   );

   assign DIN_READY = !RST && !buf_full_q;
   assign BIT_VALID = (state_q == SHIFT);
   assign LAST      = BIT_VALID && (S_OUT == sel_end(MSB_FIRST));
   assign accept    = DIN_VALID && DIN_READY;
   assign xfer      = BIT_VALID && BIT_READY;

   always_comb begin
      state_d    = state_q;
      i_out_d    = i_out_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      byte_cnt_d = byte_cnt_q;
      sel_load   = 1'b0;
      sel_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               i_out_d  = DIN;
               sel_load = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (xfer && LAST) begin
               byte_cnt_d = byte_cnt_q + 8'd1;
               // Buffer full implies DIN_READY low, so the two refill paths never collide.
               if (buf_full_q) begin
                  i_out_d    = buf_q;
                  buf_full_d = 1'b0;
                  sel_load   = 1'b1;
               end else if (accept) begin
                  i_out_d  = DIN;
                  sel_load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               sel_en = xfer;
               if (accept) begin
                  buf_d      = DIN;
                  buf_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         i_out_q    <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         i_out_q    <= i_out_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign I_OUT    = i_out_q;
   assign BYTE_CNT = byte_cnt_q;
endmodule
